// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor with start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operands are shifted right one digit per cycle, so the adder always
  // reads the low digit; the partial result fills in from the top.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT:0]   dsum;
  logic             last;
  logic             c_msb;

  // One DIGIT-bit add per cycle plus the partial-result shift-in.
  always_comb begin
    dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    acc_nxt = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last    = (cnt_q == CW'(N - 1));
    // Carry into the top bit of this digit; on the last digit this is the
    // carry into bit WIDTH-1 used for signed overflow.
    c_msb   = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start is honoured only from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, digit processing and result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_nxt;
          carry_q <= dsum[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            out  <= acc_nxt;
            cout <= dsum[DIGIT];
            ovf  <= c_msb ^ dsum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decode directly from the registered state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and parameter-sweep bench for serial_adder
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, cin, sub;
  logic [15:0] a, b, out;
  logic        cout, ovf, busy, done;

  int n_vec  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .out(out), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  // Sweep instances: (16,1), (16,16), (8,2), (32,8)
  logic        sw_start [4];
  logic        sw_cin   [4];
  logic        sw_sub   [4];
  logic [31:0] sw_a     [4];
  logic [31:0] sw_b     [4];
  logic [31:0] sw_out   [4];
  logic        sw_cout  [4];
  logic        sw_ovf   [4];
  logic        sw_busy  [4];
  logic        sw_done  [4];
  logic [15:0] o0, o1;
  logic [7:0]  o2;
  logic [31:0] o3;

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_w16d1 (
    .clk(clk), .rst(rst), .start(sw_start[0]), .a(sw_a[0][15:0]), .b(sw_b[0][15:0]),
    .cin(sw_cin[0]), .sub(sw_sub[0]), .out(o0), .cout(sw_cout[0]), .ovf(sw_ovf[0]),
    .busy(sw_busy[0]), .done(sw_done[0])
  );
  serial_adder #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
    .clk(clk), .rst(rst), .start(sw_start[1]), .a(sw_a[1][15:0]), .b(sw_b[1][15:0]),
    .cin(sw_cin[1]), .sub(sw_sub[1]), .out(o1), .cout(sw_cout[1]), .ovf(sw_ovf[1]),
    .busy(sw_busy[1]), .done(sw_done[1])
  );
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .start(sw_start[2]), .a(sw_a[2][7:0]), .b(sw_b[2][7:0]),
    .cin(sw_cin[2]), .sub(sw_sub[2]), .out(o2), .cout(sw_cout[2]), .ovf(sw_ovf[2]),
    .busy(sw_busy[2]), .done(sw_done[2])
  );
  serial_adder #(.WIDTH(32), .DIGIT(8)) u_w32d8 (
    .clk(clk), .rst(rst), .start(sw_start[3]), .a(sw_a[3]), .b(sw_b[3]),
    .cin(sw_cin[3]), .sub(sw_sub[3]), .out(o3), .cout(sw_cout[3]), .ovf(sw_ovf[3]),
    .busy(sw_busy[3]), .done(sw_done[3])
  );

  always_comb begin
    sw_out[0] = 32'(o0);
    sw_out[1] = 32'(o1);
    sw_out[2] = 32'(o2);
    sw_out[3] = o3;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] out;
    logic        cout;
    logic        ovf;
  } vec_t;

  // Drive one operation on the 16/4 DUT and collect what it reports.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic su, output logic [15:0] o, output logic co,
                       output logic ov, output int lat, output int bcnt, output int both);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = su; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~su; cin = ~ci;
    lat = 0; bcnt = 0; both = 0;
    while (1) begin
      if (busy) bcnt++;
      if (busy && done) both++;
      if (done || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
    o = out; co = cout; ov = ovf;
  endtask

  task automatic test_reset();
    logic [15:0] o; logic co, ov; int lat, bcnt, both;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out, cout, ovf, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               out, cout, ovf, busy, done);
    end
    rst = 1'b0;
    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, o, co, ov, lat, bcnt, both);
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({out, cout, ovf, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: out=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               out, cout, ovf, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, o, co, ov, lat, bcnt, both);
    n_vec++;
    if (o !== 16'h0002 || lat !== 4) begin
      n_fail++;
      $display("FAIL reset_recover: out=%h lat=%0d, want out=0002 lat=4", o, lat);
    end
  endtask

  task automatic test_add();
    logic [15:0] o; logic co, ov; int lat, bcnt, both;
    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, o, co, ov, lat, bcnt, both);
    n_vec++;
    if (o !== 16'h2201 || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: out=%h cout=%b ovf=%b, want 2201 0 0", o, co, ov);
    end
    n_vec++;
    if (lat !== 4 || bcnt !== 4 || both !== 0) begin
      n_fail++;
      $display("FAIL add_timing: lat=%0d busy_cycles=%0d overlap=%0d, want 4 4 0", lat, bcnt, both);
    end
  endtask

  task automatic test_wrap_sub();
    vec_t tv[7];
    logic [15:0] o; logic co, ov; int lat, bcnt, both;
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv[2] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[5] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, o, co, ov, lat, bcnt, both);
      n_vec++;
      if (o !== tv[i].out || co !== tv[i].cout || ov !== tv[i].ovf || lat !== 4 || both !== 0) begin
        n_fail++;
        $display("FAIL arith[%0d] %h %s %h cin=%b: got out=%h cout=%b ovf=%b lat=%0d, want out=%h cout=%b ovf=%b lat=4",
                 i, tv[i].a, tv[i].sub ? "-" : "+", tv[i].b, tv[i].cin, o, co, ov, lat,
                 tv[i].out, tv[i].cout, tv[i].ovf);
      end
    end
  endtask

  task automatic test_handshake();
    int lat;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a     = (i == 0) ? 16'hFFFF : 16'($urandom);
      b     = 16'($urandom);
      sub   = i[0];
      cin   = ~i[0];
      start = (i != 1);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 16'h3333) begin
      n_fail++;
      $display("FAIL hs_first: done=%b busy=%b out=%h, want 1 0 3333", done, busy, out);
    end
    a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h3333) begin
      n_fail++;
      $display("FAIL hs_idle_gap: busy=%b done=%b out=%h, want 0 0 3333", busy, done, out);
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_accept: busy=%b, want 1", busy);
    end
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== 4 || out !== 16'h0003) begin
      n_fail++;
      $display("FAIL hs_second: lat=%0d out=%h, want 4 0003", lat, out);
    end
  endtask

  task automatic sweep_op(input int k, input int w, input int n, input logic [31:0] av_in,
                          input logic [31:0] bv_in, input logic ci, input logic su);
    logic [31:0] mask, av, bv, bb, oe;
    logic [63:0] full;
    logic ce, ve;
    int lat;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    av   = av_in & mask;
    bv   = bv_in & mask;
    bb   = su ? (~bv & mask) : bv;
    full = 64'(av) + 64'(bb) + 64'(su ? 1'b1 : ci);
    oe   = full[31:0] & mask;
    ce   = full[w];
    ve   = (av[w-1] == bb[w-1]) && (oe[w-1] != av[w-1]);
    @(negedge clk);
    sw_a[k] = av; sw_b[k] = bv; sw_cin[k] = ci; sw_sub[k] = su; sw_start[k] = 1'b1;
    @(negedge clk);
    sw_start[k] = 1'b0; sw_a[k] = $urandom; sw_b[k] = $urandom; sw_sub[k] = ~su;
    lat = 0;
    while (!sw_done[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== n || (sw_out[k] & mask) !== oe || sw_cout[k] !== ce || sw_ovf[k] !== ve) begin
      n_fail++;
      $display("FAIL sweep w=%0d d=%0d a=%h b=%h cin=%b sub=%b: got out=%h cout=%b ovf=%b lat=%0d, want out=%h cout=%b ovf=%b lat=%0d",
               w, w / n, av, bv, ci, su, sw_out[k] & mask, sw_cout[k], sw_ovf[k], lat, oe, ce, ve, n);
    end
  endtask

  task automatic test_sweep();
    int ws[4] = '{16, 16, 8, 32};
    int ns[4] = '{16, 1, 4, 4};
    for (int k = 0; k < 4; k++) begin
      sweep_op(k, ws[k], ns[k], 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      sweep_op(k, ws[k], ns[k], 32'h8000_0000 >> (32 - ws[k]), 32'h1, 1'b0, 1'b1);
      sweep_op(k, ws[k], ns[k], 32'h7FFF_FFFF >> (32 - ws[k]), 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 1000; i++)
        sweep_op(k, ws[k], ns[k], $urandom, $urandom, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw_start[k] = 1'b0; sw_cin[k] = 1'b0; sw_sub[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0;
    end
    test_reset();
    test_add();
    test_wrap_sub();
    test_handshake();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
